ks_note_sequencer: RTL and testbench
====================================

# ks_note_sequencer

Step sequencer that sits directly upstream of the Karplus-Strong string core. It plays a small programmable table of notes by driving the string's `period` input and issuing `pluck` pulses at a configurable tempo. It runs in the KS clock domain (the divided clock that also clocks the string and the PRBS generators). It is loaded from config registers, so a tune plays without per-note SPI traffic.

## Interface
Parameters:
- `NUM_STEPS`, 8: number of table entries; power of two, 2..16.
- `DATA_WIDTH`, 8: width of a period entry; matches the string's period input.
- `TEMPO_WIDTH`, 12: width of the step-duration counter.
- `GATE_WIDTH`, 4: width of the pluck-length field.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1: KS-domain clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `enable_i` in 1: level; run the sequence while high.
- `wr_en_i` in 1: single-cycle table write strobe.
- `wr_addr_i` in $clog2(NUM_STEPS): table index to write.
- `wr_period_i` in DATA_WIDTH: period written to the entry.
- `wr_rest_i` in 1: entry is a rest (no pluck).
- `last_step_i` in $clog2(NUM_STEPS): index of the final step before wrap.
- `tempo_i` in TEMPO_WIDTH: step duration in clk_i cycles.
- `gate_len_i` in GATE_WIDTH: pluck pulse width in cycles.
- `period_o` out DATA_WIDTH: period presented to the string.
- `pluck_o` out 1: pluck request to the string.
- `step_o` out $clog2(NUM_STEPS): index of the step currently playing.
- `busy_o` out 1: high while the sequencer is not idle.

## Operation
- Table: NUM_STEPS entries of {rest, period}. Reset clears every entry to {rest=1, period=0}. Writes are accepted in any state.
- States:
  - IDLE: outputs held.
  - PLUCK: pluck_o high.
  - HOLD: pluck_o low, waiting for step end.
- IDLE -> PLUCK on the first cycle `enable_i` is sampled high.
  - step_o=0; period_o loaded from entry 0; the tempo counter loads.
- Step start: period_o latches the entry's period. If rest=1, the state goes to HOLD and pluck_o stays low.
- PLUCK -> HOLD after the gate-length cycles expire, or on step end, whichever comes first.
- Step end: the tempo counter reaches terminal count. The state returns to PLUCK (or HOLD on a rest) for the next step.
  - Next step is step_o+1.
  - The step wraps to 0 when step_o >= last_step_i, so a step_o beyond a newly lowered last_step_i wraps at its own end.
- `enable_i` low in any state forces IDLE on the next edge.
  - pluck_o and busy_o drop; period_o holds its last value; step_o returns to 0.
  - A re-enable restarts from step 0.
- Arithmetic:
  - tempo_i=0 is treated as 1.
  - gate_len_i=0 is treated as 1.
  - Effective pluck width = min(gate, tempo).
  - Counters do not wrap past terminal count.
- tempo_i and gate_len_i are sampled at each step start; changes apply from the next step.

## Timing
- Reset values: period_o=0, pluck_o=0, step_o=0, busy_o=0, state IDLE, counters 0.
- Latency: enable_i sampled high on edge N gives pluck_o, busy_o and period_o valid after edge N. All outputs are registered.
- Step duration: exactly tempo_i cycles from one step start to the next; a continuous pluck period equals tempo_i.
- Write vs. step start: a write to the entry being loaded on the same edge returns the new data (write-first bypass). A write to the playing entry otherwise takes effect on its next visit.
- Reset mid-operation: all outputs take their reset values asynchronously and the table is cleared. Operation resumes only on a new enable_i high sample after release.

## Configuration
- `KS_SEQ_SWING_EN`:
  - Defined: adds the input `swing_i` (TEMPO_WIDTH). Odd-indexed steps last tempo_i+swing_i cycles, saturating at 2^TEMPO_WIDTH-1. Even steps are unchanged.
  - Undefined: the port is absent and every step lasts tempo_i.

## Structure
- Shared package `ks_seq_pkg`: state encoding (IDLE/PLUCK/HOLD), reset-entry constant {rest=1, period=0}, and the default widths.
- One sub-module, `ks_seq_step_table`: the register file with asynchronous clear, a synchronous write port, and a combinational read port with write-first bypass.
- The FSM and counters live in the top.

## Test plan
- Reset, then load entries 0..3 = 0x40, 0x30, 0x20 (rest), 0x10; last_step=3, tempo=10, gate=3, enable -> periods 0x40, 0x30, 0x20, 0x10 every 10 cycles; 3-cycle plucks on steps 0, 1, 3 only; step_o wraps 3 -> 0.
- tempo=2, gate=5 -> pluck width clamped to 2 cycles; period 2.
- tempo=0, gate=0 -> a 1-cycle pluck every cycle; busy_o=1.
- Lower last_step from 7 to 2 while step_o=5 -> step 5 completes, then step_o=0.
- Write entry 1 on the same edge step 1 starts -> period_o shows the new value.
- Assert rst_i mid-pluck -> pluck_o=0, period_o=0, busy_o=0 immediately; after release and enable, every entry is a rest (no plucks).
- With KS_SEQ_SWING_EN, tempo=8, swing=4 -> step durations alternate 8, 12.

Source files
------------

// File: rtl/ks_seq_pkg.sv
// Shared definitions for the Karplus-Strong note sequencer: FSM state encoding,
// the value every table entry takes on reset, and the default widths.
package ks_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLUCK = 2'd1,
    S_HOLD  = 2'd2
  } seq_state_t;

  localparam int DEF_NUM_STEPS   = 8;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_TEMPO_WIDTH = 12;
  localparam int DEF_GATE_WIDTH  = 4;

  // Reset entry: a silent step {rest=1, period=0}
  localparam logic        ENTRY_RST_REST   = 1'b1;
  localparam int unsigned ENTRY_RST_PERIOD = 0;

endpackage

// File: rtl/ks_seq_step_table.sv
// Note table for ks_note_sequencer: async-cleared register file with one
// synchronous write port and a combinational, write-first read port.
module ks_seq_step_table
  import ks_seq_pkg::*;
#(
  parameter int NUM_STEPS  = DEF_NUM_STEPS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int ADDR_W    = $clog2(NUM_STEPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_period,
  input  logic                  wr_rest,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_period,
  output logic                  rd_rest
);

  logic [DATA_WIDTH-1:0] period_mem [NUM_STEPS];
  logic [NUM_STEPS-1:0]  rest_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) begin
        period_mem[i] <= DATA_WIDTH'(ENTRY_RST_PERIOD);
        rest_mem[i]   <= ENTRY_RST_REST;
      end
    end else if (wr_en) begin
      period_mem[wr_addr] <= wr_period;
      rest_mem[wr_addr]   <= wr_rest;
    end
  end

  // A write landing on the entry being read is forwarded in the same cycle
  always_comb begin
    rd_period = period_mem[rd_addr];
    rd_rest   = rest_mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_period = wr_period;
      rd_rest   = wr_rest;
    end
  end

endmodule

// File: rtl/ks_note_sequencer.sv
// Step sequencer driving the Karplus-Strong string's period and pluck inputs.
// Optional macro KS_SEQ_SWING_EN adds swing_i, lengthening odd-indexed steps.
module ks_note_sequencer
  import ks_seq_pkg::*;
#(
  parameter int NUM_STEPS   = DEF_NUM_STEPS,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TEMPO_WIDTH = DEF_TEMPO_WIDTH,
  parameter int GATE_WIDTH  = DEF_GATE_WIDTH,
  localparam int ADDR_W     = $clog2(NUM_STEPS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [DATA_WIDTH-1:0]  wr_period_i,
  input  logic                   wr_rest_i,
  input  logic [ADDR_W-1:0]      last_step_i,
  input  logic [TEMPO_WIDTH-1:0] tempo_i,
  input  logic [GATE_WIDTH-1:0]  gate_len_i,
`ifdef KS_SEQ_SWING_EN
  input  logic [TEMPO_WIDTH-1:0] swing_i,
`endif
  output logic [DATA_WIDTH-1:0]  period_o,
  output logic                   pluck_o,
  output logic [ADDR_W-1:0]      step_o,
  output logic                   busy_o
);

  seq_state_t             state, state_nxt;
  logic [ADDR_W-1:0]      step_q, step_nxt;
  logic [DATA_WIDTH-1:0]  period_q, period_nxt;
  logic [TEMPO_WIDTH-1:0] tempo_cnt, tempo_nxt;
  logic [GATE_WIDTH-1:0]  gate_cnt, gate_nxt;
  logic                   pluck_q, busy_q;

  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0]  rd_period;
  logic                   rd_rest;
  logic [TEMPO_WIDTH-1:0] tempo_eff, dur;
  logic [GATE_WIDTH-1:0]  gate_eff;
  logic                   start;

  ks_seq_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_table (
    .clk      (clk_i),
    .rst      (rst_i),
    .wr_en    (wr_en_i),
    .wr_addr  (wr_addr_i),
    .wr_period(wr_period_i),
    .wr_rest  (wr_rest_i),
    .rd_addr  (rd_addr),
    .rd_period(rd_period),
    .rd_rest  (rd_rest)
  );

  // The table always looks at the step that would start on the next edge
  always_comb begin
    if (state == S_IDLE || step_q >= last_step_i) rd_addr = '0;
    else                                          rd_addr = step_q + ADDR_W'(1);
  end

  always_comb begin
    tempo_eff = (tempo_i == '0) ? TEMPO_WIDTH'(1) : tempo_i;
    gate_eff  = (gate_len_i == '0) ? GATE_WIDTH'(1) : gate_len_i;
`ifdef KS_SEQ_SWING_EN
    begin
      logic [TEMPO_WIDTH:0] sum;
      sum = {1'b0, tempo_eff} + {1'b0, swing_i};
      if (rd_addr[0]) dur = sum[TEMPO_WIDTH] ? '1 : sum[TEMPO_WIDTH-1:0];
      else            dur = tempo_eff;
    end
`else
    dur = tempo_eff;
`endif
  end

  always_comb begin
    state_nxt  = state;
    step_nxt   = step_q;
    period_nxt = period_q;
    tempo_nxt  = (tempo_cnt != '0) ? tempo_cnt - TEMPO_WIDTH'(1) : tempo_cnt;
    gate_nxt   = (gate_cnt != '0) ? gate_cnt - GATE_WIDTH'(1) : gate_cnt;
    start      = 1'b0;

    unique case (state)
      S_IDLE:  start = enable_i;
      S_PLUCK: begin
        if (tempo_cnt == '0)     start     = 1'b1;
        else if (gate_cnt == '0) state_nxt = S_HOLD;
      end
      S_HOLD:  start = (tempo_cnt == '0);
      default: state_nxt = S_IDLE;
    endcase

    // Counters load terminal-count-relative values so a step lasts exactly dur cycles
    if (start) begin
      step_nxt   = rd_addr;
      period_nxt = rd_period;
      state_nxt  = rd_rest ? S_HOLD : S_PLUCK;
      tempo_nxt  = dur - TEMPO_WIDTH'(1);
      gate_nxt   = gate_eff - GATE_WIDTH'(1);
    end

    if (!enable_i) begin
      state_nxt  = S_IDLE;
      step_nxt   = '0;
      period_nxt = period_q;
      tempo_nxt  = '0;
      gate_nxt   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      step_q    <= '0;
      period_q  <= '0;
      tempo_cnt <= '0;
      gate_cnt  <= '0;
      pluck_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_q    <= step_nxt;
      period_q  <= period_nxt;
      tempo_cnt <= tempo_nxt;
      gate_cnt  <= gate_nxt;
      pluck_q   <= (state_nxt == S_PLUCK);
      busy_q    <= (state_nxt != S_IDLE);
    end
  end

  assign period_o = period_q;
  assign pluck_o  = pluck_q;
  assign step_o   = step_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed self-checking bench for ks_note_sequencer; swing checks are built
// when KS_SEQ_SWING_EN is defined.
module tb_ks_note_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        wr_en_i;
  logic [2:0]  wr_addr_i;
  logic [7:0]  wr_period_i;
  logic        wr_rest_i;
  logic [2:0]  last_step_i;
  logic [11:0] tempo_i;
  logic [3:0]  gate_len_i;
`ifdef KS_SEQ_SWING_EN
  logic [11:0] swing_i;
`endif
  logic [7:0]  period_o;
  logic        pluck_o;
  logic [2:0]  step_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  ks_note_sequencer #(
    .NUM_STEPS  (8),
    .DATA_WIDTH (8),
    .TEMPO_WIDTH(12),
    .GATE_WIDTH (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_period_i(wr_period_i),
    .wr_rest_i  (wr_rest_i),
    .last_step_i(last_step_i),
    .tempo_i    (tempo_i),
    .gate_len_i (gate_len_i),
`ifdef KS_SEQ_SWING_EN
    .swing_i    (swing_i),
`endif
    .period_o   (period_o),
    .pluck_o    (pluck_o),
    .step_o     (step_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [7:0] p, input logic r);
    wr_en_i = 1'b1; wr_addr_i = a; wr_period_i = p; wr_rest_i = r;
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  // Go idle for one edge, apply new settings, then start; returns at the c=0 sample
  task automatic restart(input logic [11:0] t, input logic [3:0] g, input logic [2:0] l);
    enable_i = 1'b0;
    @(negedge clk_i);
    tempo_i = t; gate_len_i = g; last_step_i = l;
    enable_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    logic [7:0] exp_per [4];
    int s;
    exp_per[0] = 8'h40; exp_per[1] = 8'h30; exp_per[2] = 8'h20; exp_per[3] = 8'h10;

    rst_i = 1'b1; enable_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0;
    wr_period_i = '0; wr_rest_i = 1'b0; last_step_i = 3'd3;
    tempo_i = 12'd10; gate_len_i = 4'd3;
`ifdef KS_SEQ_SWING_EN
    swing_i = '0;
`endif
    #1;
    check("rst_period", period_o, 0);
    check("rst_pluck", pluck_o, 0);
    check("rst_step", step_o, 0);
    check("rst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    write_entry(3'd0, 8'h40, 1'b0);
    write_entry(3'd1, 8'h30, 1'b0);
    write_entry(3'd2, 8'h20, 1'b1);
    write_entry(3'd3, 8'h10, 1'b0);
    check("idle_busy", busy_o, 0);

    // Basic tune: tempo 10, gate 3, step 2 is a rest
    enable_i = 1'b1;
    @(negedge clk_i);
    for (int c = 0; c < 40; c++) begin
      s = (c / 10) % 4;
      check("t1_step", step_o, s);
      check("t1_period", period_o, exp_per[s]);
      check("t1_pluck", pluck_o, ((c % 10) < 3 && s != 2) ? 1 : 0);
      check("t1_busy", busy_o, 1);
      @(negedge clk_i);
    end

    // Disable: outputs drop, period held, step back to 0
    enable_i = 1'b0;
    @(negedge clk_i);
    check("dis_pluck", pluck_o, 0);
    check("dis_busy", busy_o, 0);
    check("dis_step", step_o, 0);
    check("dis_period", period_o, 8'h40);

    // Gate longer than tempo: pluck clamped to the 2-cycle step
    restart(12'd2, 4'd5, 3'd3);
    for (int c = 0; c < 16; c++) begin
      s = (c / 2) % 4;
      check("t2_step", step_o, s);
      check("t2_pluck", pluck_o, (s != 2) ? 1 : 0);
      @(negedge clk_i);
    end

    // tempo=0, gate=0 behave as 1: new step and pluck every cycle
    restart(12'd0, 4'd0, 3'd1);
    for (int c = 0; c < 8; c++) begin
      check("t3_step", step_o, c % 2);
      check("t3_period", period_o, exp_per[c % 2]);
      check("t3_pluck", pluck_o, 1);
      check("t3_busy", busy_o, 1);
      @(negedge clk_i);
    end

    // Lower last_step 7 -> 2 while step 5 plays
    restart(12'd4, 4'd1, 3'd7);
    for (int c = 0; c < 40; c++) begin
      case (c)
        0:  check("t4_step0", step_o, 0);
        20: check("t4_step5a", step_o, 5);
        22: check("t4_step5b", step_o, 5);
        23: check("t4_step5c", step_o, 5);
        24: check("t4_wrap", step_o, 0);
        28: check("t4_step1", step_o, 1);
        32: check("t4_step2", step_o, 2);
        36: check("t4_wrap2", step_o, 0);
        default: ;
      endcase
      if (c == 21) last_step_i = 3'd2;
      @(negedge clk_i);
    end

    // Write to entry 1 on the edge where step 1 starts: bypass shows new period
    restart(12'd4, 4'd2, 3'd3);
    check("t5_period0", period_o, 8'h40);
    @(negedge clk_i); @(negedge clk_i); @(negedge clk_i);
    wr_en_i = 1'b1; wr_addr_i = 3'd1; wr_period_i = 8'h55; wr_rest_i = 1'b0;
    @(negedge clk_i);
    wr_en_i = 1'b0;
    check("t5_step", step_o, 1);
    check("t5_period", period_o, 8'h55);
    check("t5_pluck", pluck_o, 1);
    @(negedge clk_i);
    check("t5_pluck2", pluck_o, 1);

    // Async reset mid-pluck
    rst_i = 1'b1;
    #1;
    check("t6_pluck", pluck_o, 0);
    check("t6_period", period_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_step", step_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int c = 0; c < 16; c++) begin
      check("t6_rest_pluck", pluck_o, 0);
      check("t6_rest_period", period_o, 0);
      check("t6_rest_busy", busy_o, 1);
      check("t6_rest_step", step_o, (c / 4) % 4);
      @(negedge clk_i);
    end

`ifdef KS_SEQ_SWING_EN
    // Swing: even steps 8 cycles, odd steps 12
    swing_i = 12'd4;
    restart(12'd8, 4'd1, 3'd3);
    for (int c = 0; c < 48; c++) begin
      case (c)
        7:  check("sw_s0_end", step_o, 0);
        8:  check("sw_s1_start", step_o, 1);
        19: check("sw_s1_end", step_o, 1);
        20: check("sw_s2_start", step_o, 2);
        27: check("sw_s2_end", step_o, 2);
        28: check("sw_s3_start", step_o, 3);
        39: check("sw_s3_end", step_o, 3);
        40: check("sw_wrap", step_o, 0);
        default: ;
      endcase
      @(negedge clk_i);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
